servo_pulse_decoder: RTL and testbench
======================================

# servo_pulse_decoder

Receive-side counterpart of the servo pulse driver: measures the high time of an incoming servo pulse (24 MHz clock, 30 ms frame) and recovers the 8-bit position code. It uses the same linear mapping as the driver, width = 11990 + 170·data cycles. The block sits behind an external feedback/loopback pin and feeds position telemetry to the controller. A driver-to-decoder round trip is lossless.

## Interface
- OFFSET, 11990: pulse width in cycles that maps to code 0
- STEP, 170: cycles per code step
- MIN_WIDTH, 6000: pulses shorter than this are errors
- MAX_WIDTH, 60000: pulses longer than this are errors
- FRAME_TIMEOUT, 1440000: cycles without a rising edge before the signal is declared lost (two frames)
- clk  in  1  system clock, 24 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  decoder enable; low forces the FSM to IDLE
- pulse_in  in  1  asynchronous servo pulse input
- data  out  8  last decoded position code
- data_valid  out  1  one-cycle strobe; data updated this cycle
- pulse_error  out  1  one-cycle strobe; pulse width out of range
- signal_lost  out  1  level; no valid frame within FRAME_TIMEOUT

## Operation
- pulse_in passes through a 2-flop synchronizer (sync), with both flops reset to 1. All edge logic uses sync only.
- width counter: 17 bits, saturating at 131071. frame counter: 21 bits, saturating.
- FSM states:
  - WAIT_LOW: entered after reset. Moves to IDLE once sync = 0, so a pulse already in progress is never measured.
  - IDLE: when sync = 1, load width = 1, clear frame counter, go to MEASURE.
  - MEASURE: while sync = 1, increment width. When sync = 0, evaluate width:
    - width < MIN_WIDTH or width > MAX_WIDTH: pulse_error = 1 next cycle, go to IDLE, data unchanged.
    - otherwise: load rem = (width > OFFSET) ? width − OFFSET : 0, set q = 0, go to CONVERT.
  - CONVERT: each cycle, if rem ≥ STEP and q ≠ 255, then rem −= STEP and q += 1. Otherwise data ← q, data_valid = 1, signal_lost ← 0, go to IDLE.
- Result is floor((width − OFFSET)/STEP), clamped to 0..255. Widths below OFFSET give 0.
- Frame counter increments every cycle in every state except while enable = 0. When it reaches FRAME_TIMEOUT, signal_lost ← 1. Only a data_valid clears signal_lost.
- A pulse stuck high longer than FRAME_TIMEOUT sets signal_lost while still in MEASURE. The eventual falling edge then yields pulse_error.
- enable = 0: FSM goes to IDLE, width and frame counters clear, strobes are 0. data and signal_lost hold.
- Reset values: data = 0, data_valid = 0, pulse_error = 0, signal_lost = 1, state = WAIT_LOW, counters = 0.
- Reset mid-pulse or mid-CONVERT abandons the measurement with no strobe. The next pulse is decoded only after a low level has been seen.

## Timing
- Input latency: 2 cycles through the synchronizer. Both edges are delayed equally, so the measured width equals the true high time in cycles.
- data_valid is asserted q + 1 cycles after the first cycle with sync = 0 in MEASURE, where q is the decoded code. Worst case is 256 cycles, well inside the 30 ms frame.
- pulse_error is asserted exactly 1 cycle after the first cycle with sync = 0 in MEASURE.
- data_valid and pulse_error are never high in the same cycle. Each fires at most once per pulse.
- Rising edges that arrive during CONVERT are ignored. The frame is lost, but no false measurement results.
- signal_lost rises on the cycle the frame counter equals FRAME_TIMEOUT, and falls with data_valid.

## Test plan
- After reset, drive pulse_in high for 11990 cycles in a 720000-cycle frame → data = 0, data_valid one cycle. Then drive a 55340-cycle pulse → data = 255.
- Pulse of 28990 cycles → data = 100. data_valid is asserted exactly 101 cycles after the synchronized falling edge, and signal_lost drops from 1 to 0.
- Pulse of 5000 cycles after a valid code of 42 → pulse_error strobe, data stays 42, no data_valid. A 60001-cycle pulse → pulse_error. A 60000-cycle pulse → data = 255 (clamped).
- No rising edge for 1440000 cycles → signal_lost = 1 on that cycle. The next 20490-cycle pulse → data = 50, signal_lost = 0.
- Assert reset halfway through a pulse → no strobe, pulse ignored. The following full pulse of 45990 cycles → data = 200.
- Loopback from the servo driver sweeping data 0..255 → the decoder reproduces every code exactly, with no pulse_error.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures servo pulse high time and recovers the 8-bit position code
//   clk         in   system clock (24 MHz)
//   reset       in   synchronous active-high reset
//   enable      in   decoder enable; low parks the FSM in IDLE and clears the counters
//   pulse_in    in   asynchronous servo pulse
//   data        out  last decoded code (shows the new code during the data_valid cycle)
//   data_valid  out  one-cycle strobe, new code decoded
//   pulse_error out  one-cycle strobe, pulse width out of range
//   signal_lost out  level, no valid frame within FRAME_TIMEOUT cycles
module servo_pulse_decoder #(
    parameter int unsigned OFFSET        = 11990,
    parameter int unsigned STEP          = 170,
    parameter int unsigned MIN_WIDTH     = 6000,
    parameter int unsigned MAX_WIDTH     = 60000,
    parameter int unsigned FRAME_TIMEOUT = 1440000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pulse_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pulse_error,
    output logic       signal_lost
);
    typedef enum logic [1:0] {WAIT_LOW, IDLE, MEASURE, CONVERT} state_t;
    localparam logic [16:0] OFFSET_W  = 17'(OFFSET);
    localparam logic [16:0] STEP_W    = 17'(STEP);
    localparam logic [16:0] MIN_W     = 17'(MIN_WIDTH);
    localparam logic [16:0] MAX_W     = 17'(MAX_WIDTH);
    localparam logic [20:0] TIMEOUT_W = 21'(FRAME_TIMEOUT);
    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, sync_prev_q;
    logic [16:0] width_q, width_d, rem_q, rem_d;
    logic [20:0] frame_q, frame_d;
    logic [7:0]  q_q, q_d, data_q, data_d;
    logic        err_q, err_d, lost_q, lost_d;
    logic        sync, rise, out_of_range, step_ok, done;
    assign sync         = sync2_q;
    // Measurement starts only on a real rising edge, so a pulse that began during
    // CONVERT or while disabled is never measured from its middle.
    assign rise         = sync && !sync_prev_q;
    assign out_of_range = (width_q < MIN_W) || (width_q > MAX_W);
    assign step_ok      = (rem_q >= STEP_W) && (q_q != 8'hFF);
    assign done         = enable && (state_q == CONVERT) && !step_ok;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
            state_q     <= WAIT_LOW;
            width_q     <= '0;
            frame_q     <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            lost_q      <= 1'b1;
        end else begin
            sync1_q     <= pulse_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            state_q     <= state_d;
            width_q     <= width_d;
            frame_q     <= frame_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            data_q      <= data_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (!enable)
            state_d = IDLE;
        else
            case (state_q)
                WAIT_LOW: state_d = sync ? WAIT_LOW : IDLE;
                IDLE:     state_d = rise ? MEASURE : IDLE;
                MEASURE:  state_d = sync ? MEASURE : (out_of_range ? IDLE : CONVERT);
                CONVERT:  state_d = step_ok ? CONVERT : IDLE;
                default:  state_d = WAIT_LOW;
            endcase
    end
    always_comb begin
        width_d = width_q;
        frame_d = '0;
        rem_d   = rem_q;
        q_d     = q_q;
        data_d  = done ? q_q : data_q;
        err_d   = 1'b0;
        lost_d  = lost_q;
        if (!enable) begin
            width_d = '0;
        end else begin
            frame_d = (frame_q == '1) ? frame_q : frame_q + 21'd1;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        width_d = 17'd1;
                        frame_d = '0;
                    end
                end
                MEASURE: begin
                    if (sync) begin
                        width_d = (width_q == '1) ? width_q : width_q + 17'd1;
                    end else if (out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        rem_d = (width_q > OFFSET_W) ? width_q - OFFSET_W : '0;
                        q_d   = '0;
                    end
                end
                CONVERT: begin
                    if (step_ok) begin
                        rem_d = rem_q - STEP_W;
                        q_d   = q_q + 8'd1;
                    end
                end
                default: ;
            endcase
            lost_d = done ? 1'b0 : ((frame_d == TIMEOUT_W) ? 1'b1 : lost_q);
        end
    end
    always_comb begin
        data_valid  = done;
        data        = done ? q_q : data_q;
        pulse_error = err_q && enable;
        signal_lost = lost_q;
    end
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder: directed checks of a scaled decoder plus one full-size decode
module tb_servo_pulse_decoder;
    localparam int OFS = 120, STP = 2, MINW = 60, MAXW = 700, TMO = 2000;
    logic clk = 0, reset = 1, enable = 1, pulse_in = 0, pulse_in_f = 0;
    logic [7:0] data, data_f, v_data, f_data;
    logic data_valid, pulse_error, signal_lost, data_valid_f, pulse_error_f, signal_lost_f;
    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_valid = 0, n_err = 0, n_both = 0, v_cyc = 0, e_cyc = 0, lost_cyc = 0;
    int f_valid = 0, f_err = 0, f_cyc = 0;
    int rise_cyc = 0, fall_cyc = 0;
    always #5 clk = ~clk;
    servo_pulse_decoder #(.OFFSET(OFS), .STEP(STP), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
                          .FRAME_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in), .data(data),
        .data_valid(data_valid), .pulse_error(pulse_error), .signal_lost(signal_lost));
    servo_pulse_decoder dut_f (
        .clk(clk), .reset(reset), .enable(1'b1), .pulse_in(pulse_in_f), .data(data_f),
        .data_valid(data_valid_f), .pulse_error(pulse_error_f), .signal_lost(signal_lost_f));
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            v_data = data;
            v_cyc = cyc;
        end
        if (pulse_error) begin
            n_err++;
            e_cyc = cyc;
        end
        if (data_valid && pulse_error) n_both++;
        if (signal_lost && lost_cyc < 0) lost_cyc = cyc;
        if (data_valid_f) begin
            f_valid++;
            f_data = data_f;
            f_cyc = cyc;
        end
        if (pulse_error_f) f_err++;
    end
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic pulse(input int w, input int gap);
        @(negedge clk);
        pulse_in = 1;
        rise_cyc = cyc;
        repeat (w) @(negedge clk);
        pulse_in = 0;
        fall_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask
    task automatic expect_code(input string tag, input int w, input int code);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        pulse(w, 300);
        check({tag, " valid"}, n_valid - v0, 1);
        check({tag, " err"}, n_err - e0, 0);
        check({tag, " strobe data"}, v_data, code);
        check({tag, " data"}, data, code);
    endtask
    task automatic expect_err(input string tag, input int w, input int held);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        pulse(w, 300);
        check({tag, " valid"}, n_valid - v0, 0);
        check({tag, " err"}, n_err - e0, 1);
        check({tag, " err latency"}, e_cyc - fall_cyc, 3);
        check({tag, " data held"}, data, held);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int v0, e0;
        repeat (3) @(negedge clk);
        check("rst data", data, 0);
        check("rst valid", data_valid, 0);
        check("rst err", pulse_error, 0);
        check("rst lost", signal_lost, 1);
        reset = 0;
        repeat (5) @(negedge clk);
        expect_code("zero", OFS, 0);
        check("zero lost", signal_lost, 0);
        expect_code("max", OFS + STP * 255, 255);
        expect_code("c100", OFS + STP * 100, 100);
        check("c100 latency", v_cyc - fall_cyc, 103);
        expect_code("c42", OFS + STP * 42, 42);
        expect_err("short", 30, 42);
        expect_err("over", MAXW + 1, 42);
        expect_code("at_max", MAXW, 255);
        expect_code("at_min", MINW, 0);
        expect_err("under", MINW - 1, 0);
        expect_code("floor", OFS + 1, 0);
        expect_code("c1", OFS + 3, 1);
        lost_cyc = -1;
        pulse(OFS + STP * 100, TMO + 100);
        check("timeout rise", lost_cyc - rise_cyc, TMO + 3);
        check("timeout lost", signal_lost, 1);
        expect_code("c50", OFS + STP * 50, 50);
        check("c50 lost", signal_lost, 0);
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        pulse_in = 1;
        repeat (400) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        check("midrst lost", signal_lost, 1);
        reset = 0;
        repeat (400) @(negedge clk);
        pulse_in = 0;
        repeat (300) @(negedge clk);
        check("midrst valid", n_valid - v0, 0);
        check("midrst err", n_err - e0, 0);
        check("midrst data", data, 0);
        expect_code("c200", OFS + STP * 200, 200);
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        pulse_in = 1;
        repeat (200) @(negedge clk);
        enable = 0;
        repeat (20) @(negedge clk);
        enable = 1;
        repeat (200) @(negedge clk);
        pulse_in = 0;
        repeat (300) @(negedge clk);
        check("endis valid", n_valid - v0, 0);
        check("endis err", n_err - e0, 0);
        check("endis data", data, 200);
        expect_code("c65", OFS + STP * 65, 65);
        v0 = n_valid;
        e0 = n_err;
        pulse(OFS + STP * 255, 50);
        pulse(300, 350);
        check("overlap valid", n_valid - v0, 1);
        check("overlap err", n_err - e0, 0);
        check("overlap data", data, 255);
        for (int c = 0; c < 256; c += 15) expect_code($sformatf("sweep%0d", c), OFS + STP * c, c);
        expect_code("sweep255", OFS + STP * 255, 255);
        check("both strobes", n_both, 0);
        check("full lost before", signal_lost_f, 1);
        v0 = f_valid;
        @(negedge clk);
        pulse_in_f = 1;
        repeat (28990) @(negedge clk);
        pulse_in_f = 0;
        fall_cyc = cyc;
        repeat (300) @(negedge clk);
        check("full valid", f_valid - v0, 1);
        check("full data", data_f, 100);
        check("full strobe data", f_data, 100);
        check("full latency", f_cyc - fall_cyc, 103);
        check("full lost after", signal_lost_f, 0);
        check("full err", f_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
